// File: rtl/epb_wb_slave_fabric_if.sv
// Bus bundle between the EPB bridge master side, the fabric, and its slave ports.
interface epb_wb_slave_fabric_if #(
  parameter int NUM_SLAVES = 8
);
  logic                       wbm_cyc_i;
  logic                       wbm_stb_i;
  logic                       wbm_we_i;
  logic [3:0]                 wbm_sel_i;
  logic [31:0]                wbm_adr_i;
  logic [31:0]                wbm_dat_i;
  logic [31:0]                wbm_dat_o;
  logic                       wbm_ack_o;
  logic                       wbm_err_o;
  logic [NUM_SLAVES-1:0]      wbs_cyc_o;
  logic [NUM_SLAVES-1:0]      wbs_stb_o;
  logic                       wbs_we_o;
  logic [3:0]                 wbs_sel_o;
  logic [31:0]                wbs_adr_o;
  logic [31:0]                wbs_dat_o;
  logic [32*NUM_SLAVES-1:0]   wbs_dat_i;
  logic [NUM_SLAVES-1:0]      wbs_ack_i;
  logic [NUM_SLAVES-1:0]      wbs_err_i;

  // Fabric view.
  modport slave (
    input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i
  );

  // Environment view: bridge plus the attached slaves.
  modport master (
    output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i
  );
endinterface

// File: rtl/epb_wb_slave_fabric.sv
// Stretches the bridge's one-cycle command into a held Wishbone cycle to one
// address-decoded slave; a timeout guarantees an ack or err always returns.
//
// state | meaning
// IDLE  | waiting for a master command
// WAIT  | slave cyc/stb held, waiting for ack/err or timeout
// DERR  | decode miss; err pulse is on the bus this cycle
module epb_wb_slave_fabric #(
  parameter int NUM_SLAVES    = 8,
  parameter int SLAVE_SEL_LSB = 20,
  parameter int TIMEOUT       = 1023
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  epb_wb_slave_fabric_if.slave  bus,
  output logic [15:0]           err_count
);

  typedef enum logic [1:0] {IDLE, WAIT, DERR} state_t;

  localparam int             TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TC_LOAD = TW'(TIMEOUT - 1);
  localparam logic [4:0]     NS      = 5'(NUM_SLAVES);

  state_t                 state_q, state_d;
  logic [NUM_SLAVES-1:0]  cyc_q, cyc_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic [31:0]            dat_q, dat_d;
  logic [31:0]            adr_q, wdat_q;
  logic [3:0]             sel_q;
  logic                   we_q;
  logic [15:0]            err_cnt_q;
  logic                   latch;

  logic [3:0]             idx_in;
  logic                   idx_valid;
  logic [NUM_SLAVES-1:0]  dec_hot;
  logic                   req;
  logic                   sel_ack, sel_err;
  logic [31:0]            rd_slice;

  assign idx_in    = bus.wbm_adr_i[SLAVE_SEL_LSB +: 4];
  assign idx_valid = ({1'b0, idx_in} < NS);
  assign req       = bus.wbm_cyc_i & bus.wbm_stb_i;

  // cyc_q is one-hot on the addressed slave during WAIT, so it doubles as
  // the response mask; responses from any other slave fall away here.
  assign sel_ack = |(bus.wbs_ack_i & cyc_q);
  assign sel_err = |(bus.wbs_err_i & cyc_q);

  always_comb begin
    dec_hot  = '0;
    rd_slice = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      dec_hot[k] = ({1'b0, idx_in} == 5'(k));
      if (cyc_q[k]) rd_slice = bus.wbs_dat_i[32*k +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    timer_d = timer_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          latch = 1'b1;
          if (idx_valid) begin
            cyc_d   = dec_hot;
            timer_d = TC_LOAD;
            state_d = WAIT;
          end else begin
            err_d   = 1'b1;
            dat_d   = '0;
            state_d = DERR;
          end
        end
      end
      WAIT: begin
        if (sel_err) begin
          cyc_d   = '0;
          err_d   = 1'b1;
          dat_d   = '0;
          state_d = IDLE;
        end else if (sel_ack) begin
          cyc_d   = '0;
          ack_d   = 1'b1;
          dat_d   = rd_slice;
          state_d = IDLE;
        end else if (timer_q == '0) begin
          cyc_d   = '0;
          err_d   = 1'b1;
          dat_d   = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DERR: begin
        state_d = IDLE;
      end
      default: begin
        cyc_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      timer_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      adr_q     <= '0;
      wdat_q    <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      timer_q <= timer_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      if (latch) begin
        adr_q  <= bus.wbm_adr_i;
        wdat_q <= bus.wbm_dat_i;
        sel_q  <= bus.wbm_sel_i;
        we_q   <= bus.wbm_we_i;
      end
      // Counted on the same edge that raises the err pulse.
      if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.wbs_cyc_o = cyc_q;
  assign bus.wbs_stb_o = cyc_q;
  assign bus.wbs_we_o  = we_q;
  assign bus.wbs_sel_o = sel_q;
  assign bus.wbs_adr_o = adr_q;
  assign bus.wbs_dat_o = wdat_q;
  assign bus.wbm_ack_o = ack_q;
  assign bus.wbm_err_o = err_q;
  assign bus.wbm_dat_o = dat_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_epb_wb_slave_fabric.sv
// Self-checking bench: directed vector table, reset-abort sequence, and
// randomized commands checked against a transaction-level outcome model.
module tb_epb_wb_slave_fabric;
  localparam int NS = 8;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] err_count;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_errs = 0;

  epb_wb_slave_fabric_if #(.NUM_SLAVES(NS)) bus ();

  epb_wb_slave_fabric #(.NUM_SLAVES(NS), .SLAVE_SEL_LSB(20), .TIMEOUT(TO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus.slave),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    int          delay;      // WAIT cycle (0 = first cyc cycle) the slave responds on
    bit          use_err;
    bit          both;
    logic [31:0] rdat;
    bit          spur;       // neighbouring slaves toggle ack/err every cycle
    bit          exp_ack;
    bit          exp_err;
    int          exp_cyc;    // cycles slave cyc is high
    int          exp_pulse;  // observation cycle of the master pulse
    logic [31:0] exp_dat;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outcome of one command, from the addressing, response and timeout rules.
  task automatic model(inout vec_t v);
    int idx;
    idx = int'(v.adr[23:20]);
    v.exp_ack = 1'b0;
    v.exp_err = 1'b0;
    v.exp_dat = 32'h0;
    if (idx >= NS) begin
      v.exp_err = 1'b1; v.exp_cyc = 0; v.exp_pulse = 0;
    end else if (v.delay < TO) begin
      v.exp_cyc = v.delay + 1; v.exp_pulse = v.delay + 1;
      if (v.use_err || v.both) v.exp_err = 1'b1;
      else begin v.exp_ack = 1'b1; v.exp_dat = v.rdat; end
    end else begin
      v.exp_err = 1'b1; v.exp_cyc = TO; v.exp_pulse = TO;
    end
  endtask

  task automatic clear_slaves();
    bus.wbs_ack_i = '0;
    bus.wbs_err_i = '0;
  endtask

  task automatic run_txn(input vec_t v);
    int idx, ack_n, err_n, ack_c, err_c;
    logic [7:0]  hot, exp_cyc;
    logic [31:0] pulse_dat;
    idx = int'(v.adr[23:20]);
    hot = 8'h0;
    if (idx < NS) hot[idx] = 1'b1;
    ack_n = 0; err_n = 0; ack_c = -1; err_c = -1; pulse_dat = 32'hx;
    for (int k = 0; k < NS; k++)
      bus.wbs_dat_i[32*k +: 32] = (k == idx) ? v.rdat : {16'hDEAD, 16'(k)};
    bus.wbm_adr_i = v.adr;
    bus.wbm_we_i  = v.we;
    bus.wbm_sel_i = v.sel;
    bus.wbm_dat_i = v.wdat;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
    step();
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
    bus.wbm_dat_i = $urandom;
    for (int c = 0; c < 40; c++) begin
      exp_cyc = (c < v.exp_cyc) ? hot : 8'h0;
      check("wbs_cyc_o", 32'(bus.wbs_cyc_o), 32'(exp_cyc));
      check("wbs_stb_o", 32'(bus.wbs_stb_o), 32'(exp_cyc));
      if (bus.wbs_cyc_o != 0) begin
        check("wbs_adr_o", bus.wbs_adr_o, v.adr);
        check("wbs_dat_o", bus.wbs_dat_o, v.wdat);
        check("wbs_sel_o", 32'(bus.wbs_sel_o), 32'(v.sel));
        check("wbs_we_o",  32'(bus.wbs_we_o),  32'(v.we));
      end
      if (bus.wbm_ack_o) begin ack_n++; ack_c = c; pulse_dat = bus.wbm_dat_o; end
      if (bus.wbm_err_o) begin err_n++; err_c = c; pulse_dat = bus.wbm_dat_o; end
      clear_slaves();
      if (v.spur) begin
        bus.wbs_ack_i[(idx + 1) % NS] = 1'b1;
        bus.wbs_err_i[(idx + 2) % NS] = 1'b1;
      end
      if (c == v.delay && idx < NS) begin
        if (v.use_err || v.both) bus.wbs_err_i[idx] = 1'b1;
        if (!v.use_err || v.both) bus.wbs_ack_i[idx] = 1'b1;
      end
      step();
    end
    clear_slaves();
    check("ack_pulses", 32'(ack_n), 32'(v.exp_ack));
    check("err_pulses", 32'(err_n), 32'(v.exp_err));
    if (v.exp_ack) check("ack_cycle", 32'(ack_c), 32'(v.exp_pulse));
    if (v.exp_err) check("err_cycle", 32'(err_c), 32'(v.exp_pulse));
    check("pulse_dat", pulse_dat, v.exp_dat);
    check("dat_hold", bus.wbm_dat_o, v.exp_dat);
    if (v.exp_err && exp_errs < 16'hFFFF) exp_errs++;
    check("err_count", 32'(err_count), 32'(exp_errs));
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    vecs[0] = '{adr:32'h0020_0010, we:1'b0, sel:4'hF, wdat:32'h0, delay:3, use_err:0, both:0,
                rdat:32'hCAFE_0002, spur:0, exp_ack:1, exp_err:0, exp_cyc:4, exp_pulse:4, exp_dat:32'hCAFE_0002};
    vecs[1] = '{adr:32'h0000_0004, we:1'b1, sel:4'b0011, wdat:32'h1234_5678, delay:0, use_err:0, both:0,
                rdat:32'h0000_0000, spur:0, exp_ack:1, exp_err:0, exp_cyc:1, exp_pulse:1, exp_dat:32'h0};
    vecs[2] = '{adr:32'h00A0_0000, we:1'b0, sel:4'hF, wdat:32'h0, delay:0, use_err:0, both:0,
                rdat:32'h5555_AAAA, spur:1, exp_ack:0, exp_err:1, exp_cyc:0, exp_pulse:0, exp_dat:32'h0};
    vecs[3] = '{adr:32'h0050_0000, we:1'b0, sel:4'hF, wdat:32'h0, delay:99, use_err:0, both:0,
                rdat:32'h7777_0005, spur:0, exp_ack:0, exp_err:1, exp_cyc:16, exp_pulse:16, exp_dat:32'h0};
    vecs[4] = '{adr:32'h0030_0000, we:1'b0, sel:4'hF, wdat:32'h0, delay:2, use_err:0, both:1,
                rdat:32'h3333_0003, spur:1, exp_ack:0, exp_err:1, exp_cyc:3, exp_pulse:3, exp_dat:32'h0};
    vecs[5] = '{adr:32'h0070_0ABC, we:1'b0, sel:4'h5, wdat:32'h0, delay:15, use_err:0, both:0,
                rdat:32'hBEEF_0007, spur:1, exp_ack:1, exp_err:0, exp_cyc:16, exp_pulse:16, exp_dat:32'hBEEF_0007};
    vecs[6] = '{adr:32'h0080_0000, we:1'b1, sel:4'h1, wdat:32'h9, delay:0, use_err:0, both:0,
                rdat:32'h1, spur:0, exp_ack:0, exp_err:1, exp_cyc:0, exp_pulse:0, exp_dat:32'h0};

    rst = 1'b1;
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; bus.wbm_we_i = 1'b0;
    bus.wbm_sel_i = '0; bus.wbm_adr_i = '0; bus.wbm_dat_i = '0;
    bus.wbs_dat_i = '0;
    clear_slaves();
    step(); step();
    check("rst_cyc", 32'(bus.wbs_cyc_o), 32'h0);
    check("rst_ack", 32'(bus.wbm_ack_o), 32'h0);
    check("rst_err", 32'(bus.wbm_err_o), 32'h0);
    check("rst_dat", bus.wbm_dat_o, 32'h0);
    check("rst_adr", bus.wbs_adr_o, 32'h0);
    check("rst_wdat", bus.wbs_dat_o, 32'h0);
    check("rst_sel_we", {27'h0, bus.wbs_sel_o, bus.wbs_we_o}, 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Reset while a slave cycle is held open: nothing must answer it.
    bus.wbm_adr_i = 32'h0010_0000;
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
    step();
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
    step();
    check("abort_cyc_before", 32'(bus.wbs_cyc_o), 32'h02);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_errs = 0;
    check("abort_cyc", 32'(bus.wbs_cyc_o), 32'h0);
    check("abort_err_count", 32'(err_count), 32'h0);
    bus.wbs_ack_i = 8'hFF;
    bus.wbs_err_i = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      step();
      check("abort_no_ack", 32'(bus.wbm_ack_o), 32'h0);
      check("abort_no_err", 32'(bus.wbm_err_o), 32'h0);
      check("abort_cyc_idle", 32'(bus.wbs_cyc_o), 32'h0);
    end
    clear_slaves();
    step();
    run_txn(vecs[0]);

    for (int i = 0; i < 50; i++) begin
      rv.adr     = {8'h00, 4'($urandom_range(0, 11)), 20'($urandom)};
      rv.we      = 1'($urandom);
      rv.sel     = 4'($urandom);
      rv.wdat    = $urandom;
      rv.delay   = int'($urandom_range(0, 20));
      rv.use_err = ($urandom_range(0, 3) == 0);
      rv.both    = ($urandom_range(0, 7) == 0);
      rv.rdat    = $urandom;
      rv.spur    = 1'($urandom);
      model(rv);
      run_txn(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/epb_wb_slave_fabric.md
Name: epb_wb_slave_fabric

Overview:
- Wishbone fabric directly downstream of the EPB-to-Wishbone bridge, in the bridge's Wishbone clock domain.
- Converts the bridge's single-cycle cyc/stb command pulse into a held, standard Wishbone cycle to exactly one of NUM_SLAVES slaves, selected by address.
- Returns a single-cycle ack or err pulse with registered read data.
- A timeout counter guarantees a response, so the EPB bus never hangs on an absent or dead slave.

Parameters:
- NUM_SLAVES, 8, number of slave ports (1..16).
- SLAVE_SEL_LSB, 20, LSB of the slave index field in the address; each slave owns a 2^SLAVE_SEL_LSB-byte window.
- TIMEOUT, 1023, cycles in WAIT with no slave response before err is returned (>=2).

Ports:
- wb_clk_i  in  1  clock, all logic rising-edge.
- wb_rst_i  in  1  synchronous active-high reset.
- wbm_cyc_i  in  1  master command strobe (one-cycle pulse from bridge).
- wbm_stb_i  in  1  master strobe, same timing as cyc.
- wbm_we_i  in  1  1 = write.
- wbm_sel_i  in  4  byte enables.
- wbm_adr_i  in  32  byte address.
- wbm_dat_i  in  32  write data.
- wbm_dat_o  out  32  read data, valid with wbm_ack_o.
- wbm_ack_o  out  1  one-cycle completion pulse.
- wbm_err_o  out  1  one-cycle error pulse.
- wbs_cyc_o  out  NUM_SLAVES  per-slave cyc, one-hot or zero.
- wbs_stb_o  out  NUM_SLAVES  per-slave stb, equal to wbs_cyc_o.
- wbs_we_o  out  1  registered we.
- wbs_sel_o  out  4  registered sel.
- wbs_adr_o  out  32  registered full address.
- wbs_dat_o  out  32  registered write data.
- wbs_dat_i  in  32*NUM_SLAVES  slave read data; slave k at bits [32k+31:32k].
- wbs_ack_i  in  NUM_SLAVES  slave acks.
- wbs_err_i  in  NUM_SLAVES  slave errors.
- err_count  out  16  saturating count of err responses (slave err, decode miss, timeout).

Behaviour:
- Reset values: all wbs_cyc_o/stb_o = 0, wbm_ack_o = 0, wbm_err_o = 0, wbm_dat_o = 0, wbs_adr_o/dat_o/sel_o/we_o = 0, err_count = 0, state IDLE, timer 0.
- Reset mid-transaction: cyc drops at the reset edge; no ack/err is produced for the aborted cycle.
- Slave index: idx = wbm_adr_i[SLAVE_SEL_LSB+3:SLAVE_SEL_LSB]; slave is valid when idx < NUM_SLAVES.
- FSM states: IDLE, WAIT, DERR.
- IDLE, on cycle T with wbm_cyc_i & wbm_stb_i:
  - Register adr, dat, sel, we, idx.
  - Valid idx: at T+1, wbs_cyc_o[idx] = wbs_stb_o[idx] = 1; go WAIT; timer cleared.
  - Invalid idx: go DERR; no slave cyc asserted.
- WAIT, evaluated each cycle, in this priority:
  1. wbs_err_i[idx]: cyc/stb low next cycle; wbm_err_o pulses next cycle; wbm_dat_o = 0; go IDLE.
  2. wbs_ack_i[idx]: cyc/stb low next cycle; wbm_ack_o pulses next cycle; wbm_dat_o = registered wbs_dat_i slice idx; go IDLE.
  3. timer == TIMEOUT-1: cyc/stb low next cycle; wbm_err_o pulses next cycle; wbm_dat_o = 0; go IDLE.
  4. Otherwise timer increments.
- Simultaneous events in WAIT: err beats ack; ack or err arriving on the timeout cycle beats the timeout.
- Latency: slave ack on cycle N gives wbm_ack_o on N+1. Zero-wait slave: request at T, slave cyc at T+1, slave ack at T+1, master ack at T+2.
- Acks/errs from non-selected slaves are ignored in every state. Slave ack/err seen in IDLE or DERR is ignored.
- DERR: wbm_err_o pulses for one cycle, wbm_dat_o = 0, then IDLE. Decode-miss err appears at T+1.
- wbm_ack_o and wbm_err_o are never high together; each is exactly one cycle wide per command.
- wbm_dat_o holds its value until the next response.
- New master strobe while not IDLE: ignored, no effect on the current cycle. The bridge never issues one.
- err_count: +1 on every wbm_err_o pulse; saturates at 0xFFFF; no wrap.
- Slave-side registered address/data/sel/we remain stable throughout WAIT.

Test Plan:
- Read slave 2 at adr 0x0020_0010, slave acks 3 cycles after cyc with dat 0xCAFE_0002 -> wbs_cyc_o = 8'b0000_0100 for 4 cycles, wbm_ack_o single pulse one cycle after slave ack, wbm_dat_o = 0xCAFE_0002, err_count = 0.
- Write slave 0, adr 0x0000_0004, dat 0x1234_5678, sel 4'b0011, zero-wait slave -> wbs_dat_o/sel_o/we_o = 0x1234_5678/0011/1 while cyc high; ack at T+2.
- Address 0x00A0_0000 (idx 10, NUM_SLAVES 8) -> no wbs_cyc_o, wbm_err_o at T+1, wbm_dat_o = 0, err_count = 1.
- Slave 5 never responds, TIMEOUT = 16 -> cyc high exactly 16 cycles, then wbm_err_o pulse, err_count increments.
- Slave 3 raises ack and err in the same cycle, plus slave 4 acks spuriously -> one wbm_err_o only, no wbm_ack_o, slave 4 ignored.
- Assert wb_rst_i for one cycle while in WAIT -> all cyc low next edge, no ack/err generated, next command completes normally.
